ft_tx_arbiter: RTL
==================

# ft_tx_arbiter

Packet arbiter for the FT232H synchronous FIFO write port, in the `ft_clkout` (60 MHz) domain between the on-chip byte producers and the `ft_bus`/`ft_wr_n` pins. Producers are AD9826 pixel stream, MCP3008 samples and register readback, each behind its own CDC FIFO. The block grants whole packets round-robin and frames each with a 2-byte header. It writes bytes under `ft_txe_n` flow control, then pulses `ft_siwu_n` to flush the FT232H when no traffic remains.

## Interface
- `N_SRC`, default 3: number of requesters, 2..4.
- `HDR_TAG`, default 4'hA: upper nibble of header byte 0.
- `clk` in 1: `ft_clkout`-domain clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_req` in N_SRC: packet pending, level.
- `src_len` in 8·N_SRC: payload length minus 1 (1..256 bytes); sampled at grant.
- `src_data` in 8·N_SRC: payload byte.
- `src_valid` in N_SRC: payload byte valid.
- `src_last` in N_SRC: producer's end-of-packet marker.
- `src_ready` out N_SRC: byte accepted when valid&ready.
- `src_grant` out N_SRC: one-hot, packet in progress.
- `rx_busy` in 1: read side owns the bus; no new grant while high.
- `ft_txe_n` in 1: FT232H TX FIFO has space when low.
- `ft_wr_n` out 1: write strobe, active low.
- `ft_data` out 8: byte to `ft_bus`.
- `ft_drive` out 1: FPGA drives `ft_bus`.
- `ft_siwu_n` out 1: send-immediate, active low.
- `len_err` out 1: sticky, `src_last` disagreed with `src_len`.
- `err_clr` in 1: clears `len_err`.

## Operation
- States: IDLE, HDR, LEN, PAY, SIWU.
- One output byte register `obuf`/`ovalid`.
- Transfer ("fire") occurs on a rising edge with `ovalid`=1 and `ft_txe_n`=0.
- `ft_wr_n` = ~(`ovalid` & ~`ft_txe_n`), combinational; `ft_txe_n` is synchronous to `clk`.
- IDLE:
  - If any `src_req` and !`rx_busy`, grant the first requester at or after `rr_ptr` (wrapping).
  - Latch `cnt`=`src_len`, set `src_grant`.
  - Load `obuf`={HDR_TAG,2'b00,src_id[1:0]}, go HDR.
- HDR: on fire, load `obuf`=latched len-1 byte, go LEN.
- LEN: on fire, go PAY.
- PAY:
  - `src_ready`[g] = (!`ovalid` | fire), and only while bytes remain.
  - Each accepted byte loads `obuf`; `cnt` decrements after every accepted byte except the final one.
  - The accepted byte with `cnt`=0 is the final byte.
  - Compare `src_last` to (`cnt`==0) on each accepted byte; set `len_err` on mismatch.
  - The packet always ends on the count; a premature `src_last` does not end it.
  - After the final byte fires: clear grant, set `rr_ptr`=g+1 mod N_SRC.
  - Then go SIWU if no `src_req` is pending, else IDLE.
- SIWU: `ft_siwu_n`=0 for exactly one cycle, then IDLE. A request arriving during SIWU waits one cycle.
- `ft_drive`=1 from grant through the cycle of the final fire; it is never 0 while `ft_wr_n`=0.
- `err_clr` and a new error in the same cycle: the error wins.

## Timing
- Reset values:
  - `ft_wr_n`=1, `ft_siwu_n`=1, `ft_drive`=0, `ft_data`=0.
  - `src_ready`=0, `src_grant`=0, `len_err`=0, `rr_ptr`=0, state IDLE.
- Latency:
  - Request in IDLE at edge k gives grant and header in `obuf` after edge k.
  - With `ft_txe_n` low, the header fires at edge k+1, the len byte at k+2, and payload byte 0 at k+3.
- Sustained throughput: 1 byte/clk while `ft_txe_n`=0 and `src_valid`=1.
- `ft_txe_n` high mid-packet: `obuf` held, no byte lost or duplicated, `src_ready` low; resumes in the cycle `ft_txe_n` returns low.
- `src_valid` gaps in PAY: `ovalid` drops, `ft_wr_n`=1, `ft_drive` stays 1.
- `rx_busy` is checked only in IDLE; a granted packet always completes.
- `src_req` dropped after grant is ignored.
- Reset mid-packet: everything returns to reset values immediately. The partial packet is abandoned; the host resynchronises on HDR_TAG.

## Structure
- Shared package `ccd_pkg`:
  - HDR_TAG and source id constants (SRC_AD9826=0, SRC_MCP3008=1, SRC_REGS=2).
  - State encoding.
- No sub-module: a round-robin priority pick is a function, not an instance.

## Test plan
- Single packet: src1 req, len=8'h02, `ft_txe_n`=0 → `ft_data` sequence A1, 02, d0, d1, d2 on consecutive cycles; then `ft_siwu_n` low 1 cycle; `len_err`=0.
- Round-robin: src0 and src2 both request continuously, len=0 → packet order src0, src2, src0, src2; headers A0, A2, A0, A2; no SIWU between packets.
- Backpressure: 4-byte payload with `ft_txe_n` high for 5 cycles after byte 1 fires → host receives exactly 4 payload bytes in order; `ft_wr_n` high throughout the stall.
- Length error: len=3 with `src_last` on the 2nd byte → 4 payload bytes still sent; `len_err`=1 until `err_clr`.
- Bus ownership: `rx_busy` high with src0 pending → no grant and `ft_drive`=0; grant on the cycle after `rx_busy` falls.
- Reset mid-packet: assert `rst_n` low during PAY → all outputs at reset values the same cycle; a new request after release starts with a header byte.

Source files
------------

// File: rtl/ccd_pkg.sv
// ccd_pkg: shared constants for the CCD readout FT232H transmit path.
// Header tag, producer ids, arbiter state encoding and the round-robin pick.
package ccd_pkg;

    localparam logic [3:0] HDR_TAG     = 4'hA;

    localparam logic [1:0] SRC_AD9826  = 2'd0;
    localparam logic [1:0] SRC_MCP3008 = 2'd1;
    localparam logic [1:0] SRC_REGS    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_PAY,
        ST_SIWU
    } tx_state_t;

    // First requester at or after ptr, wrapping at n; ptr if none request.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] req,
        input logic [1:0] ptr,
        input int         n
    );
        logic [1:0] id;
        logic       hit;
        int         idx;
        id  = ptr;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!hit && i < n && req[idx]) begin
                id  = idx[1:0];
                hit = 1'b1;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/ft_tx_arbiter_if.sv
// ft_tx_arbiter_if: producer side and FT232H write-port signals of the arbiter.
// master drives requests and pin inputs; slave is the arbiter itself.
interface ft_tx_arbiter_if #(
    parameter int N_SRC = 3
);
    logic [N_SRC-1:0]   src_req;
    logic [8*N_SRC-1:0] src_len;
    logic [8*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]   src_valid;
    logic [N_SRC-1:0]   src_last;
    logic [N_SRC-1:0]   src_ready;
    logic [N_SRC-1:0]   src_grant;
    logic               rx_busy;
    logic               ft_txe_n;
    logic               ft_wr_n;
    logic [7:0]         ft_data;
    logic               ft_drive;
    logic               ft_siwu_n;
    logic               len_err;
    logic               err_clr;

    modport master (
        output src_req, src_len, src_data, src_valid, src_last,
        output rx_busy, ft_txe_n, err_clr,
        input  src_ready, src_grant,
        input  ft_wr_n, ft_data, ft_drive, ft_siwu_n, len_err
    );

    modport slave (
        input  src_req, src_len, src_data, src_valid, src_last,
        input  rx_busy, ft_txe_n, err_clr,
        output src_ready, src_grant,
        output ft_wr_n, ft_data, ft_drive, ft_siwu_n, len_err
    );

endinterface

// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: round-robin packet arbiter for the FT232H sync FIFO write port.
// Each packet goes out as header, length byte, payload; SIWU flushes when idle.
module ft_tx_arbiter #(
    parameter int         N_SRC   = 3,
    parameter logic [3:0] HDR_TAG = ccd_pkg::HDR_TAG
) (
    input  logic           clk,
    input  logic           rst_n,
    ft_tx_arbiter_if.slave bus
);
    import ccd_pkg::*;

    tx_state_t   r_state;
    logic [7:0]  r_obuf;
    logic        r_ovalid;
    logic [7:0]  r_cnt;
    logic        r_rem;
    logic [1:0]  r_gid;
    logic [3:0]  r_gnt;
    logic [1:0]  r_rr;
    logic        r_drive;
    logic        r_siwu_n;
    logic        r_err;

    logic [3:0]  w_req;
    logic [3:0]  w_valid;
    logic [3:0]  w_last;
    logic [31:0] w_len;
    logic [31:0] w_data;
    logic [1:0]  w_pick;
    logic [7:0]  w_plen;
    logic [7:0]  w_gdata;
    logic        w_gvalid;
    logic        w_glast;
    logic        w_any;
    logic        w_fire;
    logic        w_rdy;
    logic        w_acc;
    logic        w_fin;

    // Pad the per-source vectors to four lanes so 2-bit ids index them.
    assign w_req    = 4'(bus.src_req);
    assign w_valid  = 4'(bus.src_valid);
    assign w_last   = 4'(bus.src_last);
    assign w_len    = 32'(bus.src_len);
    assign w_data   = 32'(bus.src_data);

    assign w_any    = |bus.src_req;
    assign w_pick   = rr_pick(w_req, r_rr, N_SRC);
    assign w_plen   = w_len[{w_pick, 3'b000} +: 8];
    assign w_gdata  = w_data[{r_gid, 3'b000} +: 8];
    assign w_gvalid = w_valid[r_gid];
    assign w_glast  = w_last[r_gid];

    // A byte leaves obuf whenever it holds one and the FT232H has room.
    assign w_fire   = r_ovalid & ~bus.ft_txe_n;

    // Payload byte 0 is taken while the length byte fires, so the
    // payload follows the header with no bubble.
    assign w_rdy    = r_rem &
                      (((r_state == ST_PAY) & (~r_ovalid | w_fire)) |
                       ((r_state == ST_LEN) & w_fire));
    assign w_acc    = w_rdy & w_gvalid;
    assign w_fin    = (r_state == ST_PAY) & ~r_rem & w_fire;

    assign bus.src_ready = N_SRC'(r_gnt & {4{w_rdy}});
    assign bus.src_grant = N_SRC'(r_gnt);
    assign bus.ft_wr_n   = ~w_fire;
    assign bus.ft_data   = r_obuf;
    assign bus.ft_drive  = r_drive;
    assign bus.ft_siwu_n = r_siwu_n;
    assign bus.len_err   = r_err;

    // Packet framing FSM: grant, header, length, payload, optional flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_obuf   <= 8'h00;
            r_ovalid <= 1'b0;
            r_cnt    <= 8'h00;
            r_rem    <= 1'b0;
            r_gid    <= 2'd0;
            r_gnt    <= 4'b0000;
            r_rr     <= 2'd0;
            r_drive  <= 1'b0;
            r_siwu_n <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any && !bus.rx_busy) begin
                        r_gid    <= w_pick;
                        r_gnt    <= 4'b0001 << w_pick;
                        r_cnt    <= w_plen;
                        r_rem    <= 1'b1;
                        r_drive  <= 1'b1;
                        r_obuf   <= {HDR_TAG, 2'b00, w_pick};
                        r_ovalid <= 1'b1;
                        r_state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_fire) begin
                        r_obuf  <= r_cnt;
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (w_fire) begin
                        r_state <= ST_PAY;
                        if (!w_acc) r_ovalid <= 1'b0;
                    end
                end
                ST_PAY: begin
                    if (w_fin) begin
                        r_ovalid <= 1'b0;
                        r_gnt    <= 4'b0000;
                        r_drive  <= 1'b0;
                        r_rr     <= (r_gid == 2'(N_SRC - 1)) ? 2'd0
                                                             : r_gid + 2'd1;
                        if (w_any) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state  <= ST_SIWU;
                            r_siwu_n <= 1'b0;
                        end
                    end else if (w_fire && !w_acc) begin
                        r_ovalid <= 1'b0;
                    end
                end
                ST_SIWU: begin
                    r_siwu_n <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_acc) begin
                r_obuf   <= w_gdata;
                r_ovalid <= 1'b1;
                if (r_cnt == 8'h00) r_rem <= 1'b0;
                else                r_cnt <= r_cnt - 8'h01;
            end
        end
    end

    // Sticky length error; a new mismatch beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_acc && (w_glast != (r_cnt == 8'h00))) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end
    end

endmodule
